// File: rtl/wb_rr_arbiter_if.sv
// wb_rr_arbiter_if: one Wishbone classic bus segment; master drives the request, slave drives the termination.
interface wb_rr_arbiter_if #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 32,
   parameter int SELECT_WIDTH = DATA_WIDTH / 8
);
   logic [ADDR_WIDTH-1:0]   adr;
   logic [DATA_WIDTH-1:0]   wdat;
   logic [DATA_WIDTH-1:0]   rdat;
   logic                    we;
   logic [SELECT_WIDTH-1:0] sel;
   logic                    stb;
   logic                    cyc;
   logic                    ack;
   logic                    err;
   logic                    rty;
   modport master (output adr, wdat, we, sel, stb, cyc, input rdat, ack, err, rty);
   modport slave  (input adr, wdat, we, sel, stb, cyc, output rdat, ack, err, rty);
endinterface

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: two-master round-robin Wishbone classic arbiter, grant locked for the whole CYC.
// Define WB_ARB_TIMEOUT_EN to add a watchdog that answers hung slave cycles with ERR.
module wb_rr_arbiter #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 32,
   parameter int SELECT_WIDTH = DATA_WIDTH / 8,
   parameter int TIMEOUT      = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   wb_rr_arbiter_if.slave        wbm0,
   wb_rr_arbiter_if.slave        wbm1,
   wb_rr_arbiter_if.master       wbs,
   output logic [1:0]            gnt_o
);
   if (!(DATA_WIDTH inside {8, 16, 32, 64}) || SELECT_WIDTH != DATA_WIDTH / 8 || ADDR_WIDTH < 1 ||
       TIMEOUT < 1 || TIMEOUT > 65535)
      $error("wb_rr_arbiter: illegal parameter set");
   typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
   state_t state;
   logic   last_served;
   logic   to_err;
   logic   g0, g1;
   assign g0 = gnt_o[0];
   assign g1 = gnt_o[1];
   // gnt_o is updated together with state so it always decodes the current grant
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state       <= IDLE;
         last_served <= 1'b1;
         gnt_o       <= 2'b00;
      end else
         case (state)
            IDLE:
               if (wbm0.cyc && (!wbm1.cyc || last_served)) begin
                  state <= GNT0;
                  gnt_o <= 2'b01;
               end else if (wbm1.cyc) begin
                  state <= GNT1;
                  gnt_o <= 2'b10;
               end
            GNT0:
               if (!wbm0.cyc) begin
                  last_served <= 1'b0;
                  state       <= wbm1.cyc ? GNT1 : IDLE;
                  gnt_o       <= wbm1.cyc ? 2'b10 : 2'b00;
               end
            GNT1:
               if (!wbm1.cyc) begin
                  last_served <= 1'b1;
                  state       <= wbm0.cyc ? GNT0 : IDLE;
                  gnt_o       <= wbm0.cyc ? 2'b01 : 2'b00;
               end
            default: begin
               state <= IDLE;
               gnt_o <= 2'b00;
            end
         endcase
   assign wbs.adr  = g0 ? wbm0.adr  : g1 ? wbm1.adr  : '0;
   assign wbs.wdat = g0 ? wbm0.wdat : g1 ? wbm1.wdat : '0;
   assign wbs.we   = g0 ? wbm0.we   : g1 ? wbm1.we   : 1'b0;
   assign wbs.sel  = g0 ? wbm0.sel  : g1 ? wbm1.sel  : '0;
   assign wbs.cyc  = g0 ? wbm0.cyc  : g1 ? wbm1.cyc  : 1'b0;
   assign wbs.stb  = g0 ? wbm0.stb  : g1 ? wbm1.stb  : 1'b0;
   assign wbm0.ack  = g0 & wbs.ack;
   assign wbm0.err  = g0 & (wbs.err | to_err);
   assign wbm0.rty  = g0 & wbs.rty;
   assign wbm0.rdat = g0 ? wbs.rdat : '0;
   assign wbm1.ack  = g1 & wbs.ack;
   assign wbm1.err  = g1 & (wbs.err | to_err);
   assign wbm1.rty  = g1 & wbs.rty;
   assign wbm1.rdat = g1 ? wbs.rdat : '0;
`ifdef WB_ARB_TIMEOUT_EN
   logic [15:0] to_cnt;
   logic        to_run;
   // a grant change always drops wbs.cyc first, so to_run covers the state-change clear
   assign to_run = wbs.cyc & wbs.stb & ~(wbs.ack | wbs.err | wbs.rty);
   assign to_err = to_run && to_cnt == 16'(TIMEOUT);
   always_ff @(posedge clk or posedge rst)
      if (rst) to_cnt <= '0;
      else     to_cnt <= (to_run && !to_err) ? to_cnt + 16'd1 : '0;
`else
   assign to_err = 1'b0;
`endif
endmodule
